// File: rtl/right_shifter_seq_x2_pkg.sv
// Shared definitions for the sequential datapath units: FSM state encoding
// and the fill-bit selection used by the right shifter.
package right_shifter_seq_x2_pkg;

    // Two-bit state encoding, kept as plain constants so older units can reuse it.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Bits entering at the top on each step: {MSB, MSB-1}.
    // Arithmetic mode replicates the current sign bit, logical mode uses the
    // fill pair latched at load time.
    function automatic logic [1:0] select_fill(input logic       arith,
                                               input logic       msb,
                                               input logic [1:0] cin);
        return arith ? {msb, msb} : cin;
    endfunction

endpackage

// File: rtl/right_shifter_seq_x2_stage.sv
// Combinational right-by-2 stage built from 2:1 mux cells. With i_sh low the
// word passes through untouched and nothing is reported as shifted out.

// Basic 2:1 mux cell: i_sel=0 selects i_a, i_sel=1 selects i_b.
module mux_2x1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module right_shifter_x2_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_sh,
    input  logic [1:0]       i_fill,
    output logic [WIDTH-1:0] o_dout,
    output logic [1:0]       o_shout
);
    // Shifted candidate: fill pair drops in at the top, two LSBs fall off.
    logic [WIDTH-1:0] w_shifted;
    logic [1:0]       w_zero;

    assign w_shifted = {i_fill, i_din[WIDTH-1:2]};
    assign w_zero    = 2'b00;

    for (genvar g = 0; g < WIDTH; g++) begin : g_data
        mux_2x1 u_mux (
            .i_a   (i_din[g]),
            .i_b   (w_shifted[g]),
            .i_sel (i_sh),
            .o_y   (o_dout[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_out
        mux_2x1 u_mux (
            .i_a   (w_zero[g]),
            .i_b   (i_din[g]),
            .i_sel (i_sh),
            .o_y   (o_shout[g])
        );
    end

endmodule

// File: rtl/right_shifter_seq_x2.sv
// Multi-cycle right shifter: loads a word, then shifts it right by 2 bits per
// clock for the requested number of steps, tracking the last bits lost and a
// sticky OR of everything shifted out since the load.
module right_shifter_seq_x2
    import right_shifter_seq_x2_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_in,
    input  logic [STEP_W-1:0] i_steps,
    input  logic              i_arith,
    input  logic [1:0]        i_cin,
    output logic [WIDTH-1:0]  o_out,
    output logic [1:0]        o_cout,
    output logic              o_sticky,
    output logic              o_busy,
    output logic              o_done
);

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_out;
    logic [1:0]        r_cout;
    logic              r_sticky;
    logic [STEP_W-1:0] r_cnt;
    logic              r_arith_l;
    logic [1:0]        r_cin_l;

    logic [1:0]        w_state_nxt;
    logic              w_sh;
    logic [1:0]        w_fill;
    logic [WIDTH-1:0]  w_shift_out;
    logic [1:0]        w_shout;

    assign w_sh   = (r_state == S_SHIFT);
    assign w_fill = select_fill(r_arith_l, r_out[WIDTH-1], r_cin_l);

    right_shifter_x2_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_din   (r_out),
        .i_sh    (w_sh),
        .i_fill  (w_fill),
        .o_dout  (w_shift_out),
        .o_shout (w_shout)
    );

    // Next-state logic: IDLE -> SHIFT/DONE on start, SHIFT -> DONE on last step, DONE -> IDLE.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (i_steps == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (r_cnt <= STEP_W'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; reset wins in every state and abandons any operation.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_out     <= '0;
            r_cout    <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_arith_l <= 1'b0;
            r_cin_l   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_out     <= i_in;
                        r_cout    <= '0;
                        r_sticky  <= 1'b0;
                        r_cnt     <= i_steps;
                        r_arith_l <= i_arith;
                        r_cin_l   <= i_cin;
                    end
                end
                S_SHIFT: begin
                    r_out    <= w_shift_out;
                    r_cout   <= w_shout;
                    r_sticky <= r_sticky | (|w_shout);
                    r_cnt    <= r_cnt - STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_out    = r_out;
    assign o_cout   = r_cout;
    assign o_sticky = r_sticky;
    assign o_busy   = (r_state == S_SHIFT);
    assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_right_shifter_seq_x2.sv
// Self-checking bench for right_shifter_seq_x2 (WIDTH=4, STEP_W=2).
// Expected results are computed by a behavioural model, queued when an
// operation is launched, and compared when done is seen.
module tb_right_shifter_seq_x2;

    localparam int W  = 4;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0] out;
        logic [1:0]   cout;
        logic         sticky;
        int           lat;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [W-1:0]  i_in;
    logic [SW-1:0] i_steps;
    logic          i_arith;
    logic [1:0]    i_cin;
    logic [W-1:0]  o_out;
    logic [1:0]    o_cout;
    logic          o_sticky;
    logic          o_busy;
    logic          o_done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    right_shifter_seq_x2 #(.WIDTH(W), .STEP_W(SW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_in     (i_in),
        .i_steps  (i_steps),
        .i_arith  (i_arith),
        .i_cin    (i_cin),
        .o_out    (o_out),
        .o_cout   (o_cout),
        .o_sticky (o_sticky),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: n two-bit right shifts with the chosen fill.
    function automatic exp_t model(input logic [W-1:0] din, input int n,
                                   input logic ar, input logic [1:0] c);
        exp_t         e;
        logic [W-1:0] v;
        logic [1:0]   f;
        v        = din;
        e.cout   = 2'b00;
        e.sticky = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.cout   = v[1:0];
            e.sticky = e.sticky | (|v[1:0]);
            f        = ar ? {v[W-1], v[W-1]} : c;
            v        = {f, v[W-1:2]};
        end
        e.out = v;
        e.lat = n + 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Launch one operation from IDLE; optionally pulse start with in=1111
    // while the shifter is busy, which must have no effect.
    task automatic run_op(input logic [W-1:0] din, input int n, input logic ar,
                          input logic [1:0] c, input bit inject);
        exp_t e;
        int   cycles;
        sb.push_back(model(din, n, ar, c));
        i_start = 1'b1;
        i_in    = din;
        i_steps = SW'(n);
        i_arith = ar;
        i_cin   = c;
        tick();
        i_start = 1'b0;
        i_in    = 'x;
        i_steps = 'x;
        i_arith = 1'bx;
        i_cin   = 'x;
        cycles  = 1;
        while (!o_done && cycles < 12) begin
            check("busy_during_shift", 32'(o_busy), 32'd1);
            if (inject && cycles == 1) begin
                i_start = 1'b1;
                i_in    = 4'b1111;
                i_steps = 2'd3;
                i_arith = 1'b1;
                i_cin   = 2'b11;
            end else begin
                i_start = 1'b0;
            end
            tick();
            cycles++;
        end
        i_start = 1'b0;
        check("done_seen", 32'(o_done), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", 32'(cycles), 32'(e.lat));
            check("out",     32'(o_out), 32'(e.out));
            check("cout",    32'(o_cout), 32'(e.cout));
            check("sticky",  32'(o_sticky), 32'(e.sticky));
            check("busy_at_done", 32'(o_busy), 32'd0);
        end
        tick();
        check("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_in    = '0;
        i_steps = '0;
        i_arith = 1'b0;
        i_cin   = '0;
        tick();
        tick();
        check("rst_out",    32'(o_out), 32'd0);
        check("rst_cout",   32'(o_cout), 32'd0);
        check("rst_sticky", 32'(o_sticky), 32'd0);
        check("rst_busy",   32'(o_busy), 32'd0);
        check("rst_done",   32'(o_done), 32'd0);
        i_rst = 1'b0;
        tick();

        // Directed cases.
        run_op(4'b1011, 1, 1'b0, 2'b00, 1'b0);
        run_op(4'b1011, 2, 1'b0, 2'b01, 1'b0);
        run_op(4'b1000, 3, 1'b1, 2'b00, 1'b0);
        run_op(4'b0110, 0, 1'b0, 2'b00, 1'b0);
        run_op(4'b0111, 3, 1'b0, 2'b00, 1'b0);
        run_op(4'b0100, 2, 1'b1, 2'b11, 1'b0);
        // Start pulsed while busy must be ignored.
        run_op(4'b1011, 2, 1'b0, 2'b01, 1'b1);
        run_op(4'b0010, 3, 1'b0, 2'b10, 1'b1);

        // Reset in the middle of a shift abandons the operation.
        i_start = 1'b1;
        i_in    = 4'b1011;
        i_steps = 2'd3;
        i_arith = 1'b0;
        i_cin   = 2'b01;
        tick();
        i_start = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_out",    32'(o_out), 32'd0);
        check("midrst_cout",   32'(o_cout), 32'd0);
        check("midrst_sticky", 32'(o_sticky), 32'd0);
        check("midrst_busy",   32'(o_busy), 32'd0);
        check("midrst_done",   32'(o_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", 32'(o_done), 32'd0);
        end
        run_op(4'b1101, 1, 1'b1, 2'b00, 1'b0);

        // Random operations, back to back.
        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
